// File: rtl/tpu_accum_pkg.sv
// tpu_accum_pkg: shared FSM states and arithmetic helpers for the accumulator read-modify-write path
package tpu_accum_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   function automatic int addr_width(input int rows, input int out_cols, input int arr_cols);
      return $clog2(rows * (out_cols / arr_cols));
   endfunction
   // Operands arrive sign-extended to 64 bits, so the sum is exact before clamping to w-bit signed range
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
      logic signed [63:0] s, hi, lo;
      s = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return s > hi ? hi : (s < lo ? lo : s);
   endfunction
endpackage

// File: rtl/accum_rmw_lane.sv
// accum_rmw_lane: one column's row counter and 3-stage read-modify-write pipeline
module accum_rmw_lane import tpu_accum_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  run,
   input  logic                  accumulate,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       num_rows,
   input  logic                  psum_valid,
   input  logic [DATA_WIDTH-1:0] psum_data,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_address,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_address,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic                  bad
);
   logic [ADDR_W:0] cnt;
   logic take, s1_v, s2_v;
   logic [ADDR_W-1:0] s2_addr;
   logic [DATA_WIDTH-1:0] s1_psum, s2_psum;
   assign take = psum_valid && run && cnt < num_rows;
   assign bad = psum_valid && !take;
   assign full = cnt == num_rows;
   assign empty = !(s1_v || s2_v || wr_en);
   // Stage 1 address doubles as rd_address; stage 2 waits out the table's one-cycle read latency
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         s1_v <= 1'b0;
         rd_en <= 1'b0;
         rd_address <= '0;
         s1_psum <= '0;
         s2_v <= 1'b0;
         s2_addr <= '0;
         s2_psum <= '0;
         wr_en <= 1'b0;
         wr_address <= '0;
         wr_data <= '0;
      end else begin
         cnt <= clr ? '0 : cnt + (ADDR_W+1)'(take);
         s1_v <= take;
         rd_en <= take && accumulate;
         if (take) begin
            rd_address <= base_addr + cnt[ADDR_W-1:0];
            s1_psum <= psum_data;
         end
         s2_v <= s1_v;
         s2_addr <= rd_address;
         s2_psum <= s1_psum;
         wr_en <= s2_v;
         if (s2_v) begin
            wr_address <= s2_addr;
            wr_data <= accumulate ? DATA_WIDTH'(sat_add(64'($signed(rd_data)), 64'($signed(s2_psum)), DATA_WIDTH)) : s2_psum;
         end
      end
endmodule

// File: rtl/accum_rmw_ctrl.sv
// accum_rmw_ctrl: pass FSM and per-column read-modify-write lanes in front of the accumulator table
module accum_rmw_ctrl import tpu_accum_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_ROWS_NUM = 128,
   parameter int MAX_OUT_COLS = 128,
   parameter int SYS_ARR_COLS = 16,
   localparam int ADDR_W = addr_width(MAX_ROWS_NUM, MAX_OUT_COLS, SYS_ARR_COLS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [ADDR_W-1:0]                 base_addr,
   input  logic [ADDR_W:0]                   num_rows,
   input  logic                              accumulate,
   input  logic [SYS_ARR_COLS-1:0]           psum_valid,
   input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] psum_data,
   output logic [SYS_ARR_COLS-1:0]           rd_en,
   output logic [ADDR_W*SYS_ARR_COLS-1:0]    rd_address,
   input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] rd_data,
   output logic [SYS_ARR_COLS-1:0]           wr_en,
   output logic [ADDR_W*SYS_ARR_COLS-1:0]    wr_address,
   output logic [DATA_WIDTH*SYS_ARR_COLS-1:0] wr_data,
   output logic                              busy,
   output logic                              done,
   output logic                              ovf_err
);
   state_t state, nxt;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0] rows_q;
   logic acc_q, accept;
   logic [SYS_ARR_COLS-1:0] full, empty, bad;
   assign accept = state == IDLE && start;
   always_comb begin
      nxt = state;
      if (accept) nxt = num_rows == '0 ? DONE : RUN;
      else if (state == RUN && &full) nxt = DRAIN;
      else if (state == DRAIN && &empty) nxt = DONE;
      else if (state == DONE) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         done <= 1'b0;
         busy <= 1'b0;
         ovf_err <= 1'b0;
         base_q <= '0;
         rows_q <= '0;
         acc_q <= 1'b0;
      end else begin
         state <= nxt;
         done <= state == DONE;
         busy <= nxt != IDLE;
         ovf_err <= (ovf_err && !accept) || |bad;
         if (accept) begin
            base_q <= base_addr;
            rows_q <= num_rows;
            acc_q <= accumulate;
         end
      end
   for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_lane
      accum_rmw_lane #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_lane (
         .clk(clk),
         .reset(reset),
         .clr(accept),
         .run(state == RUN),
         .accumulate(acc_q),
         .base_addr(base_q),
         .num_rows(rows_q),
         .psum_valid(psum_valid[c]),
         .psum_data(psum_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_data(rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_en(rd_en[c]),
         .rd_address(rd_address[c*ADDR_W +: ADDR_W]),
         .wr_en(wr_en[c]),
         .wr_address(wr_address[c*ADDR_W +: ADDR_W]),
         .wr_data(wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .full(full[c]),
         .empty(empty[c]),
         .bad(bad[c])
      );
   end
endmodule

// File: tb/tb_accum_rmw_ctrl.sv
// tb_accum_rmw_ctrl: scoreboard bench with a table model and a behavioural reference of each pass
module tb_accum_rmw_ctrl;
   localparam int DW = 16, COLS = 4, AW = 10, DEPTH = 1 << AW;
   typedef struct {int addr; int data; int cyc;} exp_t;
   logic clk = 0, reset = 1, start = 0, accumulate = 0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0] num_rows = '0;
   logic [COLS-1:0] psum_valid = '0;
   logic [COLS-1:0] rd_en, wr_en;
   logic [DW*COLS-1:0] psum_data = '0;
   logic [DW*COLS-1:0] rd_data, wr_data;
   logic [AW*COLS-1:0] rd_address, wr_address;
   logic busy, done, ovf_err;
   logic signed [DW-1:0] tbl [COLS][DEPTH];
   int ref_mem [COLS][DEPTH];
   int pv [COLS][8];
   exp_t rd_q [COLS][$];
   exp_t wr_q [COLS][$];
   int cyc = 0, errors = 0, checks = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
   int p_base = 0, p_rows = 0;
   bit p_acc = 0;
   logic pl_en = 0;
   int pl_c = 0, pl_a = 0, pl_d = 0;

   accum_rmw_ctrl #(.DATA_WIDTH(DW), .MAX_ROWS_NUM(128), .MAX_OUT_COLS(32), .SYS_ARR_COLS(COLS)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .accumulate(accumulate), .psum_valid(psum_valid), .psum_data(psum_data),
      .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data),
      .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
      .busy(busy), .done(done), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Table model: one-cycle read latency, writes land on the edge
   always @(posedge clk) begin
      for (int c = 0; c < COLS; c++) begin
         if (rd_en[c]) rd_data[c*DW +: DW] <= tbl[c][rd_address[c*AW +: AW]];
         if (wr_en[c]) tbl[c][wr_address[c*AW +: AW]] <= wr_data[c*DW +: DW];
      end
      if (pl_en) tbl[pl_c][pl_a] <= DW'(pl_d);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int c = 0; c < COLS; c++) begin
            if (rd_en[c]) begin
               chk("rd_expected", int'(rd_q[c].size() != 0), 1);
               if (rd_q[c].size() != 0) begin
                  e = rd_q[c].pop_front();
                  chk("rd_addr", int'(rd_address[c*AW +: AW]), e.addr);
                  chk("rd_cycle", cyc, e.cyc);
               end
            end
            if (wr_en[c]) begin
               last_wr_cyc <= cyc;
               chk("wr_expected", int'(wr_q[c].size() != 0), 1);
               if (wr_q[c].size() != 0) begin
                  e = wr_q[c].pop_front();
                  chk("wr_addr", int'(wr_address[c*AW +: AW]), e.addr);
                  chk("wr_data", int'($signed(wr_data[c*DW +: DW])), e.data);
                  chk("wr_cycle", cyc, e.cyc);
               end
            end
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd16();
      logic signed [DW-1:0] v;
      v = DW'($urandom);
      return v;
   endfunction

   function automatic int sat16(input int v);
      return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
   endfunction

   task automatic preload(input int c, input int a, input int d);
      pl_en = 1; pl_c = c; pl_a = a; pl_d = d;
      ref_mem[c][a] = d;
      tick();
      pl_en = 0;
   endtask

   task automatic start_pass(input int base, input int rows, input bit acc, output int s);
      start = 1; base_addr = AW'(base); num_rows = (AW+1)'(rows); accumulate = acc;
      p_base = base; p_rows = rows; p_acc = acc; s = cyc;
      tick();
      start = 0;
   endtask

   // Reference: row k of a pass targets (base+k) mod depth; read at +1, write at +3
   task automatic expect_psum(input int c, input int k, input int d);
      exp_t e;
      int a, v;
      a = (p_base + k) % DEPTH;
      v = p_acc ? sat16(ref_mem[c][a] + d) : d;
      e.addr = a; e.data = 0; e.cyc = cyc + 1;
      if (p_acc) rd_q[c].push_back(e);
      e.data = v; e.cyc = cyc + 3;
      wr_q[c].push_back(e);
      ref_mem[c][a] = v;
   endtask

   task automatic feed(input int rows, input int skew, input int prob, input bit extra);
      int k [COLS];
      bit more, xtra;
      xtra = extra;
      for (int c = 0; c < COLS; c++) k[c] = 0;
      for (int t = 0; t < 2000; t++) begin
         more = 0;
         for (int c = 0; c < COLS; c++) begin
            psum_valid[c] = 0;
            if (k[c] < rows && t >= c * skew && int'($urandom_range(99)) < prob) begin
               psum_valid[c] = 1;
               psum_data[c*DW +: DW] = DW'(pv[c][k[c]]);
               expect_psum(c, k[c], pv[c][k[c]]);
               k[c]++;
            end else if (c == 0 && xtra && k[0] == rows) begin
               psum_valid[0] = 1;
               psum_data[DW-1:0] = 16'h1234;
               xtra = 0;
            end
            if (k[c] < rows) more = 1;
         end
         tick();
         if (!more) break;
      end
      psum_valid = '0;
   endtask

   task automatic finish_pass(input int d0, input int ovf_exp);
      for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
      chk("done_seen", int'(done_cnt != d0), 1);
      repeat (3) tick();
      chk("done_once", done_cnt - d0, 1);
      chk("busy_low", busy, 0);
      chk("ovf_err", ovf_err, ovf_exp);
      for (int c = 0; c < COLS; c++) begin
         chk("wr_drained", wr_q[c].size(), 0);
         chk("rd_drained", rd_q[c].size(), 0);
      end
   endtask

   task automatic rand_pass();
      int base, rows, s, d0;
      bit acc;
      base = int'($urandom_range(DEPTH - 1));
      rows = int'($urandom_range(8, 1));
      acc = 1'($urandom);
      for (int c = 0; c < COLS; c++)
         for (int k = 0; k < rows; k++) begin
            pv[c][k] = rnd16();
            if (acc) preload(c, (base + k) % DEPTH, $urandom_range(3) == 0 ? ($urandom_range(1) == 1 ? 32700 : -32700) : rnd16());
         end
      d0 = done_cnt;
      start_pass(base, rows, acc, s);
      chk("busy_high", busy, 1);
      feed(rows, int'($urandom_range(3)), 60, 0);
      finish_pass(d0, 0);
   endtask

   initial begin
      int s, d0;
      repeat (2) tick();
      chk("rst_ctrl", int'({rd_en, wr_en, busy, done, ovf_err}), 0);
      chk("rst_addr_data", int'(|{rd_address, wr_address, wr_data}), 0);
      reset = 0;
      tick();
      // overwrite: column 0 gets 10, -2, 7 at rows 5..7
      for (int c = 0; c < COLS; c++) for (int k = 0; k < 8; k++) pv[c][k] = rnd16();
      pv[0][0] = 10; pv[0][1] = -2; pv[0][2] = 7;
      d0 = done_cnt;
      start_pass(5, 3, 0, s);
      chk("busy_high", busy, 1);
      feed(3, 0, 100, 0);
      finish_pass(d0, 0);
      chk("ow_a5", tbl[0][5], 10);
      chk("ow_a6", tbl[0][6], -2);
      chk("ow_a7", tbl[0][7], 7);
      // accumulate 100 + 23
      preload(0, 5, 100);
      for (int c = 1; c < COLS; c++) preload(c, 5, rnd16());
      pv[0][0] = 23;
      d0 = done_cnt;
      start_pass(5, 1, 1, s);
      feed(1, 0, 100, 0);
      finish_pass(d0, 0);
      chk("acc_123", tbl[0][5], 123);
      // saturation both ways
      preload(0, 9, 32000);
      preload(1, 9, -32000);
      preload(2, 9, rnd16());
      preload(3, 9, rnd16());
      pv[0][0] = 1000; pv[1][0] = -1000;
      d0 = done_cnt;
      start_pass(9, 1, 1, s);
      feed(1, 0, 100, 0);
      finish_pass(d0, 0);
      chk("sat_hi", tbl[0][9], 32767);
      chk("sat_lo", tbl[1][9], -32768);
      // skewed columns
      for (int c = 0; c < COLS; c++) for (int k = 0; k < 8; k++) pv[c][k] = rnd16();
      d0 = done_cnt;
      start_pass(100, 2, 0, s);
      feed(2, 1, 100, 0);
      finish_pass(d0, 0);
      chk("done_after_wr", int'(done_cyc > last_wr_cyc), 1);
      // zero rows
      d0 = done_cnt;
      start_pass(50, 0, 0, s);
      finish_pass(d0, 0);
      chk("zero_done_lat", done_cyc - s, 2);
      // address wrap
      for (int c = 0; c < COLS; c++) begin
         preload(c, 1023, rnd16());
         preload(c, 0, rnd16());
      end
      d0 = done_cnt;
      start_pass(1023, 2, 1, s);
      feed(2, 0, 100, 0);
      finish_pass(d0, 0);
      chk("wrap_a0", tbl[2][0], ref_mem[2][0]);
      // extra psum on a finished column
      d0 = done_cnt;
      start_pass(200, 2, 0, s);
      feed(2, 1, 100, 1);
      finish_pass(d0, 1);
      d0 = done_cnt;
      start_pass(300, 1, 0, s);
      chk("ovf_cleared", ovf_err, 0);
      feed(1, 0, 100, 0);
      finish_pass(d0, 0);
      // psum outside a pass
      psum_valid[2] = 1;
      tick();
      psum_valid = '0;
      tick();
      chk("ovf_idle", ovf_err, 1);
      // reset mid-pass after one row
      d0 = done_cnt;
      start_pass(37, 3, 1, s);
      psum_valid[0] = 1;
      psum_data[DW-1:0] = 16'd1;
      tick();
      psum_valid = '0;
      chk("pre_rst_rd_en", rd_en[0], 1);
      reset = 1;
      #1;
      chk("mid_rst_ctrl", int'({rd_en, wr_en, busy, done, ovf_err}), 0);
      chk("mid_rst_addr_data", int'(|{rd_address, wr_address, wr_data}), 0);
      tick();
      reset = 0;
      repeat (6) tick();
      chk("no_done_after_rst", done_cnt - d0, 0);
      chk("busy_after_rst", busy, 0);
      for (int i = 0; i < 10; i++) rand_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/accum_rmw_ctrl.md
Name: accum_rmw_ctrl

Overview:
- Read-modify-write controller directly upstream of the accumulator table.
- Consumes per-column partial sums from the systolic array. Column skew means column c's stream starts c cycles after column 0.
- Drives the table's per-column read/write ports.
- Either accumulates each psum into the stored value (saturating add) or overwrites it, over one pass of num_rows rows starting at base_addr.

Parameters:
- DATA_WIDTH, 16, width of one psum/table word (signed).
- MAX_ROWS_NUM, 128, tallest supported matrix.
- MAX_OUT_COLS, 128, widest supported output matrix.
- SYS_ARR_COLS, 16, systolic array columns = table columns.
- ADDR_W (localparam), $clog2(MAX_ROWS_NUM*(MAX_OUT_COLS/SYS_ARR_COLS)) = 10.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pass request; honoured only in IDLE.
- base_addr  in  ADDR_W  first table row of the pass.
- num_rows  in  ADDR_W+1  rows per column in the pass; range 0..2^ADDR_W.
- accumulate  in  1  1 = RMW add, 0 = overwrite.
- psum_valid  in  SYS_ARR_COLS  per-column psum strobe.
- psum_data  in  DATA_WIDTH*SYS_ARR_COLS  signed psums; column c at [c*DATA_WIDTH +: DATA_WIDTH].
- rd_en  out  SYS_ARR_COLS  table read enables.
- rd_address  out  ADDR_W*SYS_ARR_COLS  table read addresses.
- rd_data  in  DATA_WIDTH*SYS_ARR_COLS  table read data; valid the cycle after rd_en.
- wr_en  out  SYS_ARR_COLS  table write enables.
- wr_address  out  ADDR_W*SYS_ARR_COLS  table write addresses.
- wr_data  out  DATA_WIDTH*SYS_ARR_COLS  table write data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of pass.
- ovf_err  out  1  sticky; psum_valid seen on a column already at num_rows, or outside RUN; cleared by next accepted start.

Behaviour:
- Reset (async assert): FSM=IDLE; all counters and pipeline valids cleared.
  - rd_en, wr_en, busy, done, ovf_err = 0.
  - Addresses and wr_data = 0.
  - Reset mid-pass abandons the pass; no further writes are issued.
- FSM states:
  - IDLE: start -> latch base_addr, num_rows, accumulate; clear ovf_err. Go to DONE if num_rows==0, else RUN.
  - RUN: remain until every column's row count == num_rows. Then go to DRAIN.
  - DRAIN: remain until all column pipelines are empty. Then go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
  - busy=1 in RUN, DRAIN and DONE.
- Per-column pipeline, with psum_valid[c] sampled at cycle t while in RUN and cnt[c] < num_rows:
  - t+1: if accumulate, rd_en[c]=1 with rd_address[c] = base_addr + cnt[c], mod 2^ADDR_W (wraps). psum and address are registered; cnt[c] increments.
  - t+2: rd_data[c] sampled.
  - t+3: wr_en[c]=1, wr_address[c] = same address.
    - Accumulate: wr_data[c] = sat(rd_data + psum).
    - Overwrite: wr_data[c] = psum; rd_en stays 0 but latency is identical.
- Saturation: signed add computed at DATA_WIDTH+1 bits, then clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Throughput: one psum per column per cycle, back-to-back. Addresses within a pass are distinct, so there is no RAW hazard.
- Columns are independent; arbitrary skew and gaps in psum_valid are allowed.
- psum_valid[c] with cnt[c]==num_rows, or outside RUN: ignored, no table access, ovf_err set.
- start while busy: ignored.
- Outputs are registered; rd_en/wr_en are 0 in every cycle without a valid access.

Decomposition:
- Shared package `tpu_accum_pkg`:
  - ADDR_W derivation function.
  - FSM state enum: IDLE, RUN, DRAIN, DONE.
  - Saturating-add function.
- Sub-module `accum_rmw_lane`: one column's counter, 3-stage pipeline and saturation. Instanced as an array of SYS_ARR_COLS.
- Top level holds the FSM and the all-columns-done reduction.

Test Plan:
- Overwrite pass: base=5, num_rows=3, accumulate=0.
  - Stimulus: column 0 psums 10, -2, 7 on consecutive cycles.
  - Required: wr at addrs 5, 6, 7 with 10, -2, 7; rd_en never high; done pulses once; busy then drops.
- Accumulate pass: table model holds 100 at addr 5, psum 23, accumulate=1.
  - Required: rd_en at t+1 addr 5; wr_en at t+3 addr 5, data 123.
- Saturation:
  - Stored 32000 + psum 1000 -> wr_data 32767.
  - Stored -32000 + psum -1000 -> -32768.
- Skewed columns, SYS_ARR_COLS=4: column c valid starts at cycle c, num_rows=2.
  - Required: each column writes its own 2 rows; done occurs only after column 3's last write.
- Boundaries:
  - num_rows=0: done pulses 2 cycles after start with no accesses.
  - base=1023, num_rows=2: addresses 1023 then 0.
  - Extra psum_valid beyond num_rows: ignored and ovf_err=1.
- Reset mid-RUN after 1 of 3 rows:
  - Required: all outputs 0 immediately; no later wr_en.
  - A new start then behaves normally.
